alu_regfile: RTL and testbench



---
 rtl/alu_regfile_if.sv | 32 +++
 rtl/alu_regfile.sv | 53 +++++
 tb/tb_alu_regfile.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_if.sv
// Decoder-to-datapath bus for alu_regfile: ALU operands/opcode, two read ports, one write port.
// The decoder holds the master side; the datapath core holds the slave side.
interface alu_regfile_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic [AW-1:0]   rf_raddr1;
  logic [XLEN-1:0] rf_rdata1;
  logic [AW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata2;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output alu_src1, alu_src2, alu_op,
    output rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    input  alu_result, rf_rdata1, rf_rdata2
  );

  modport slave (
    input  alu_src1, alu_src2, alu_op,
    input  rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    output alu_result, rf_rdata1, rf_rdata2
  );
endinterface

// File: rtl/alu_regfile.sv
// Single-cycle RV64 execution core: combinational 64-bit ALU plus 32xXLEN register file.
// Optional macro REGFILE_BYPASS_EN forwards the pending write data to matching read ports.
module alu_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_regfile_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_active;

  // x0 is never written, so it stays at its reset value of zero forever
  assign wr_active = bus.rf_we && (bus.rf_waddr != AW'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  always_comb begin
    bus.rf_rdata1 = regs[bus.rf_raddr1];
    bus.rf_rdata2 = regs[bus.rf_raddr2];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr_active && (bus.rf_raddr1 == bus.rf_waddr)) begin
      bus.rf_rdata1 = bus.rf_wdata;
    end
    if (rst_n && wr_active && (bus.rf_raddr2 == bus.rf_waddr)) begin
      bus.rf_rdata2 = bus.rf_wdata;
    end
`else
`endif
  end

  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      2'b00: bus.alu_result = bus.alu_src2;
      2'b01: bus.alu_result = bus.alu_src1 + bus.alu_src2;
      2'b10: bus.alu_result = {{(XLEN-1){1'b0}}, (bus.alu_src1 < bus.alu_src2)};
      2'b11: bus.alu_result = bus.alu_src1 - bus.alu_src2;
      default: bus.alu_result = '0;
    endcase
  end
endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: scoreboard of expected read/ALU values checked after each drive.
// Honours REGFILE_BYPASS_EN for the read-during-write expectation.
module tb_alu_regfile;
  logic clk;
  logic rst_n;

  alu_regfile_if #(.XLEN(64), .NREG(32)) bus ();

  alu_regfile #(.XLEN(64), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {OBS_ALU, OBS_RD1, OBS_RD2} obs_t;
  typedef struct {
    string       tag;
    obs_t        obs;
    logic [63:0] expected;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [63:0] mdl [32];
  int          num_compared;
  int          num_mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] aluModel(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'b00:   return b;
      2'b01:   return a + b;
      2'b10:   return (a < b) ? 64'd1 : 64'd0;
      default: return a - b;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] expected);
    sb_entry_t e;
    bus.alu_op   = op;
    bus.alu_src1 = a;
    bus.alu_src2 = b;
    e.tag = tag; e.obs = OBS_ALU; e.expected = expected;
    sb_q.push_back(e);
  endtask

  task automatic expectRead(input string tag, input int port, input logic [4:0] addr, input logic [63:0] expected);
    sb_entry_t e;
    if (port == 1) begin
      bus.rf_raddr1 = addr;
      e.obs = OBS_RD1;
    end else begin
      bus.rf_raddr2 = addr;
      e.obs = OBS_RD2;
    end
    e.tag = tag; e.expected = expected;
    sb_q.push_back(e);
  endtask

  task automatic drainScoreboard();
    sb_entry_t   e;
    logic [63:0] observed;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.obs)
        OBS_ALU: observed = bus.alu_result;
        OBS_RD1: observed = bus.rf_rdata1;
        default: observed = bus.rf_rdata2;
      endcase
      checkOutput(e.tag, observed, e.expected);
    end
  endtask

  // One write through the single port; the model follows only writes the DUT must accept
  task automatic writeReg(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus.rf_we    = 1'b1;
    bus.rf_waddr = addr;
    bus.rf_wdata = data;
    @(posedge clk);
    if (rst_n && addr != 5'd0) mdl[addr] = data;
    #1;
    bus.rf_we = 1'b0;
  endtask

  logic [63:0] ra, rb, rdw_exp;
  logic [4:0]  wa, a1, a2;
  logic [1:0]  rop;

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    rst_n = 1'b0;
    bus.alu_src1 = '0; bus.alu_src2 = '0; bus.alu_op = 2'b00;
    bus.rf_raddr1 = '0; bus.rf_raddr2 = '0;
    bus.rf_we = 1'b0; bus.rf_waddr = '0; bus.rf_wdata = '0;
    #2;
    expectRead("rst_rd1_x5", 1, 5'd5, 64'd0);
    expectRead("rst_rd2_x10", 2, 5'd10, 64'd0);
    drainScoreboard();

    // A write attempted across an edge while reset is held must not land
    writeReg(5'd7, 64'h55);
    expectRead("rst_write_ignored", 1, 5'd7, 64'd0);
    drainScoreboard();

    @(negedge clk);
    rst_n = 1'b1;
    writeReg(5'd5, 64'hDEAD);
    expectRead("x5_written", 1, 5'd5, 64'hDEAD);
    drainScoreboard();

    // Asynchronous reset mid-cycle with a write pending for the next edge
    @(negedge clk);
    bus.rf_we = 1'b1; bus.rf_waddr = 5'd6; bus.rf_wdata = 64'hBEEF;
    bus.rf_raddr1 = 5'd5;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    expectRead("async_rst_x5", 1, 5'd5, 64'd0);
    drainScoreboard();
    @(posedge clk);
    expectRead("rst_overrides_write", 2, 5'd6, 64'd0);
    drainScoreboard();
    @(negedge clk);
    bus.rf_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    expectRead("x6_after_release", 1, 5'd6, 64'd0);
    drainScoreboard();

    writeReg(5'd0, 64'h1234);
    expectRead("x0_rd1", 1, 5'd0, 64'd0);
    expectRead("x0_rd2", 2, 5'd0, 64'd0);
    drainScoreboard();

    writeReg(5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    expectRead("x10_rd1", 1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    expectRead("x10_rd2", 2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    drainScoreboard();

    applyStimulus("add_wrap", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    drainScoreboard();
    applyStimulus("sub_wrap", 2'b11, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    drainScoreboard();
    applyStimulus("sltu_lt", 2'b10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    drainScoreboard();
    applyStimulus("sltu_ge", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    drainScoreboard();
    applyStimulus("sltu_eq", 2'b10, 64'd42, 64'd42, 64'd0);
    drainScoreboard();
    applyStimulus("pass_src2", 2'b00, 64'h1234_5678, 64'h8000_0000, 64'h8000_0000);
    drainScoreboard();
    applyStimulus("add_plain", 2'b01, 64'd100, 64'd23, 64'd123);
    drainScoreboard();
    applyStimulus("sub_plain", 2'b11, 64'd100, 64'd23, 64'd77);
    drainScoreboard();

    // Read-during-write on x3 (old value 2, new value 7)
    writeReg(5'd3, 64'd2);
    @(negedge clk);
    bus.rf_we = 1'b1; bus.rf_waddr = 5'd3; bus.rf_wdata = 64'd7;
`ifdef REGFILE_BYPASS_EN
    rdw_exp = 64'd7;
`else
    rdw_exp = 64'd2;
`endif
    expectRead("rdw_before_rd1", 1, 5'd3, rdw_exp);
    expectRead("rdw_before_rd2", 2, 5'd3, rdw_exp);
    drainScoreboard();
    @(posedge clk);
    mdl[3] = 64'd7;
    #1;
    bus.rf_we = 1'b0;
    expectRead("rdw_after_rd1", 1, 5'd3, 64'd7);
    expectRead("rdw_after_rd2", 2, 5'd3, 64'd7);
    drainScoreboard();

    for (int i = 0; i < 24; i++) begin
      wa = 5'($urandom_range(0, 31));
      ra = {$urandom, $urandom};
      writeReg(wa, ra);
      a1 = 5'($urandom_range(0, 31));
      a2 = (i % 3 == 0) ? wa : 5'($urandom_range(0, 31));
      expectRead("rand_rd1", 1, a1, mdl[a1]);
      expectRead("rand_rd2", 2, a2, mdl[a2]);
      ra  = {$urandom, $urandom};
      rb  = (i % 4 == 0) ? ra : {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      applyStimulus("rand_alu", rop, ra, rb, aluModel(rop, ra, rb));
      drainScoreboard();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
